debounce_button_1: RTL and testbench

- Input-side counterpart to the LED blinker: conditions a raw mechanical push-button pin on the MAX10 eval kit into a clean, debounced level plus single-cycle press, release and long-press event pulses.
- Sits between the board button pin and user logic, all in the 50 MHz board clock domain.
- Internals: two-flop synchronizer, four-state debounce FSM, stability counter and hold counter.

---
 rtl/debounce_button_1.sv | 149 ++++++++++++++
 tb/tb_debounce_button_1.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_button_1.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM, registered
// press/release pulses. Long-press detection is built only when DEBOUNCE_BUTTON_1_LONG_PRESS_EN is defined.
module debounce_button_1 #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int BTN_ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic rst_n_async,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int                STAB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic              PIN_IDLE = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              w_act;
    logic              w_stab_done;
    state_t            r_state;
    logic [STAB_W-1:0] r_stab_cnt;
    logic              r_pressed;
    logic              r_press_pulse;
    logic              r_release_pulse;

    // Synchronizer resets to the idle pin level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            r_sync1 <= PIN_IDLE;
            r_sync2 <= PIN_IDLE;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_act       = r_sync2 ^ PIN_IDLE;
    assign w_stab_done = (r_stab_cnt == STAB_MAX);

    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            r_state         <= RELEASED;
            r_stab_cnt      <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (w_act) begin
                        r_state    <= PRESS_PEND;
                        r_stab_cnt <= STAB_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (!w_act) begin
                        r_state    <= RELEASED;
                        r_stab_cnt <= '0;
                    end else if (w_stab_done) begin
                        r_state       <= HELD;
                        r_stab_cnt    <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + STAB_ONE;
                    end
                end
                HELD: begin
                    if (!w_act) begin
                        r_state    <= RELEASE_PEND;
                        r_stab_cnt <= STAB_ONE;
                    end
                end
                RELEASE_PEND: begin
                    // A pressed sample aborts the release; the level never dropped.
                    if (w_act) begin
                        r_state    <= HELD;
                        r_stab_cnt <= '0;
                    end else if (w_stab_done) begin
                        r_state         <= RELEASED;
                        r_stab_cnt      <= '0;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + STAB_ONE;
                    end
                end
                default: begin
                    r_state    <= RELEASED;
                    r_stab_cnt <= '0;
                end
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

`ifdef DEBOUNCE_BUTTON_1_LONG_PRESS_EN
    localparam int                HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic              w_press_accept;
    logic              w_holding;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long_press_pulse;

    assign w_press_accept = (r_state == PRESS_PEND) && w_act && w_stab_done;
    assign w_holding      = (r_state == HELD) || (r_state == RELEASE_PEND);

    // Saturating counter: the pulse fires on the single step into HOLD_MAX, so once per press.
    always_ff @(posedge clk or negedge rst_n_async) begin
        if (!rst_n_async) begin
            r_hold_cnt         <= '0;
            r_long_press_pulse <= 1'b0;
        end else begin
            r_long_press_pulse <= 1'b0;
            if (w_press_accept) begin
                r_hold_cnt <= '0;
            end else if (w_holding && (r_hold_cnt != HOLD_MAX)) begin
                r_hold_cnt         <= r_hold_cnt + HOLD_ONE;
                r_long_press_pulse <= (r_hold_cnt == (HOLD_MAX - HOLD_ONE));
            end
        end
    end

    assign long_press_pulse = r_long_press_pulse;
`else
    assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_button_1.sv
// Bench for debounce_button_1: reset, table vectors, hand-written corner sequences and a
// randomized run checked every cycle against a run-length reference model.
module tb_debounce_button_1;

  localparam int DEB  = 4;
  localparam int LONG = 20;
`ifdef DEBOUNCE_BUTTON_1_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n_async = 1'b1;
  logic btn_raw = 1'b1;
  logic pressed, press_pulse, release_pulse, long_press_pulse;
  logic [3:0] outs;

  int n_total = 0;
  int n_bad = 0;

  // ---------------- clock / reset / dut ----------------
  always #10 clk = ~clk;

  debounce_button_1 #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n_async(rst_n_async),
    .btn_raw(btn_raw),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse)
  );

  assign outs = {pressed, press_pulse, release_pulse, long_press_pulse};

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got {pressed,press,release,long}=%b expected %b", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Level flips after DEB+1 consecutive synchronized samples disagreeing with it;
  // the synchronized sample at an edge is the raw pin value from two edges earlier.
  logic act_q[$];
  logic m_lvl = 1'b0;
  int   m_run = 0;
  int   m_hold = 0;
  logic [3:0] m_out = 4'b0000;
  logic m_a, m_pp, m_rp, m_lp;

  always @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      act_q.delete();
      act_q.push_back(1'b0);
      act_q.push_back(1'b0);
      m_lvl = 1'b0;
      m_run = 0;
      m_hold = 0;
      m_out = 4'b0000;
    end else begin
      m_a = act_q.pop_front();
      act_q.push_back(~btn_raw);
      m_pp = 1'b0;
      m_rp = 1'b0;
      m_lp = 1'b0;
      if (m_lvl && m_hold < LONG) begin
        m_hold++;
        if (LP_EN && m_hold == LONG) m_lp = 1'b1;
      end
      if (m_a != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = m_a;
          m_run = 0;
          if (m_a) begin
            m_pp = 1'b1;
            m_hold = 0;
          end else begin
            m_rp = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_out = {m_lvl, m_pp, m_rp, m_lp};
    end
  end

  // Scoreboard: every falling edge compares the DUT against the model.
  always @(negedge clk) check("model_cmp", outs, m_out);

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[16];
  logic rv;
  int   rlen;

  initial begin
    // Clean press then clean release; exp = {pressed, press_pulse, release_pulse, long_press_pulse}.
    tbl[0]  = '{1'b0, 4'b0000}; tbl[1]  = '{1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000}; tbl[3]  = '{1'b0, 4'b0000};
    tbl[4]  = '{1'b0, 4'b0000}; tbl[5]  = '{1'b0, 4'b0000};
    tbl[6]  = '{1'b0, 4'b1100}; tbl[7]  = '{1'b0, 4'b1000};
    tbl[8]  = '{1'b1, 4'b1000}; tbl[9]  = '{1'b1, 4'b1000};
    tbl[10] = '{1'b1, 4'b1000}; tbl[11] = '{1'b1, 4'b1000};
    tbl[12] = '{1'b1, 4'b1000}; tbl[13] = '{1'b1, 4'b1000};
    tbl[14] = '{1'b1, 4'b0010}; tbl[15] = '{1'b1, 4'b0000};

    // Reset: 3 cycles low with button idle, then 10 quiet cycles.
    #1 rst_n_async = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", outs, 4'b0000);
    end
    #3 rst_n_async = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_after_reset", outs, 4'b0000);
    end

    for (int i = 0; i < 16; i++) begin
      btn_raw = tbl[i].btn;
      @(negedge clk);
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    // Bounce on press: low 3, high 1, then low; press 6 edges after the final low sample.
    for (int i = 0; i <= 10; i++) begin
      btn_raw = (i == 3);
      @(negedge clk);
      check("bounce_press", outs, (i == 10) ? 4'b1100 : 4'b0000);
    end
    // Keep holding: one long pulse 20 edges after the press, then 110 quiet cycles.
    for (int i = 11; i <= 140; i++) begin
      btn_raw = 1'b0;
      @(negedge clk);
      check("long_press", outs, {1'b1, 1'b0, 1'b0, LP_EN && (i == 30)});
    end

    // Release bounce: high 2, low 1, then high; release 6 edges after the final high sample.
    for (int i = 0; i <= 11; i++) begin
      btn_raw = (i != 2);
      @(negedge clk);
      check("bounce_release", outs, (i < 9) ? 4'b1000 : ((i == 9) ? 4'b0010 : 4'b0000));
    end

    // Press with a one-sample release glitch mid-hold: the hold count keeps running.
    for (int i = 0; i <= 30; i++) begin
      btn_raw = (i == 10);
      @(negedge clk);
      if (i < 6) check("glitch_hold", outs, 4'b0000);
      else if (i == 6) check("glitch_hold", outs, 4'b1100);
      else check("glitch_hold", outs, {1'b1, 1'b0, 1'b0, LP_EN && (i == 26)});
    end
    for (int i = 0; i <= 7; i++) begin
      btn_raw = 1'b1;
      @(negedge clk);
      check("clean_release", outs, (i < 6) ? 4'b1000 : ((i == 6) ? 4'b0010 : 4'b0000));
    end

    // Reset while held: outputs clear at once, then a fresh full-latency press.
    for (int i = 0; i <= 9; i++) begin
      btn_raw = 1'b0;
      @(negedge clk);
      check("press_before_rst", outs, (i < 6) ? 4'b0000 : ((i == 6) ? 4'b1100 : 4'b1000));
    end
    #3 rst_n_async = 1'b0;
    #1 check("async_reset", outs, 4'b0000);
    @(negedge clk);
    check("in_reset", outs, 4'b0000);
    #3 rst_n_async = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      check("press_after_rst", outs, (i < 6) ? 4'b0000 : ((i == 6) ? 4'b1100 : 4'b1000));
    end

    // Randomized runs with occasional resets; the scoreboard checks every cycle.
    for (int k = 0; k < 250; k++) begin
      rv = 1'($urandom_range(0, 1));
      rlen = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
      if ($urandom_range(0, 30) == 0) begin
        #3 rst_n_async = 1'b0;
        @(negedge clk);
        #3 rst_n_async = 1'b1;
        @(negedge clk);
      end
      btn_raw = rv;
      repeat (rlen) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
